// File: rtl/fir_multichannel.sv
// Multichannel bit-serial FIR: per-channel delay lines share one double-buffered
// coefficient bank and one serial MAC with symmetric/antisymmetric pre-add.
module fir_multichannel #(
    parameter int  DataWidth  = 12,
    parameter int  CoeffWidth = 12,
    parameter int  NTaps      = 9,
    parameter int  NChannels  = 2,
    localparam int NCoeffs    = (NTaps + 1) / 2,
    localparam int ChW        = (NChannels > 1) ? $clog2(NChannels) : 1,
    localparam int CaW        = (NCoeffs > 1) ? $clog2(NCoeffs) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_sym_coeffs,
    input  logic                  i_coeff_we,
    input  logic [CaW-1:0]        i_coeff_addr,
    input  logic [CoeffWidth-1:0] i_coeff_wdata,
    input  logic                  i_coeff_commit,
    output logic                  o_commit_pend,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [ChW-1:0]        i_in_ch,
    input  logic [DataWidth-1:0]  i_x,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [ChW-1:0]        o_out_ch,
    output logic [DataWidth-1:0]  o_y,
    output logic                  o_out_sat
);
    localparam int AccW  = DataWidth + CoeffWidth + $clog2(NCoeffs) + 2;
    localparam int BitW  = $clog2(DataWidth + 1);
    localparam int TapIW = (NTaps > 1) ? $clog2(NTaps) : 1;
    localparam logic signed [AccW-1:0] YMax    = AccW'(2 ** (DataWidth - 1) - 1);
    localparam logic signed [AccW-1:0] YMin    = AccW'(-(2 ** (DataWidth - 1)));
    localparam logic signed [AccW-1:0] RndBias = AccW'(2 ** (CoeffWidth - 2));

    if ((NTaps % 2) == 0) begin : g_bad_ntaps
        $error("fir_multichannel: NTaps must be odd");
    end

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MAC = 2'd1, S_OUT = 2'd2} state_t;

    state_t                      r_state;
    logic [DataWidth-1:0]        r_line   [NChannels][NTaps];
    logic [CoeffWidth-1:0]       r_shadow [NCoeffs];
    logic [CoeffWidth-1:0]       r_active [NCoeffs];
    logic signed [AccW-1:0]      r_acc;
    logic [CaW-1:0]              r_pass;
    logic [BitW-1:0]             r_bit;
    logic [ChW-1:0]              r_ch;
    logic                        r_sym;
    logic                        r_in_ready;
    logic                        r_out_valid;
    logic [ChW-1:0]              r_out_ch;
    logic [DataWidth-1:0]        r_y;
    logic                        r_out_sat;
    logic                        r_commit_pend;

    logic                        w_go;
    logic                        w_to_idle;
    logic                        w_last_pass;
    logic [TapIW-1:0]            w_idx_a;
    logic [TapIW-1:0]            w_idx_b;
    logic [DataWidth-1:0]        w_tap_a;
    logic [DataWidth-1:0]        w_tap_b;
    logic [DataWidth-1:0]        w_tap_m;
    logic [DataWidth:0]          w_s;
    logic signed [AccW-1:0]      w_coef;
    logic signed [AccW-1:0]      w_term;
    logic signed [AccW-1:0]      w_acc_next;
    logic signed [AccW-1:0]      w_q;
    logic [DataWidth-1:0]        w_y;
    logic                        w_sat;

    assign w_go        = (r_state == S_IDLE) && i_in_valid && (int'(i_in_ch) < NChannels);
    assign w_to_idle   = (r_state == S_OUT) && r_out_valid && i_out_ready;
    assign w_last_pass = (r_pass == CaW'(NCoeffs - 1));
    assign w_idx_a     = TapIW'(r_pass);
    assign w_idx_b     = TapIW'(NTaps - 1) - TapIW'(r_pass);

    // Serial MAC step: pre-added tap pair, one bit of it per cycle, MSB weighted negative.
    always_comb begin
        w_tap_a = r_line[r_ch][w_idx_a];
        w_tap_b = r_line[r_ch][w_idx_b];
        w_tap_m = r_line[r_ch][TapIW'(NTaps / 2)];
        if (w_last_pass) begin
            w_s = {w_tap_m[DataWidth-1], w_tap_m};
        end else if (r_sym) begin
            w_s = {w_tap_a[DataWidth-1], w_tap_a} + {w_tap_b[DataWidth-1], w_tap_b};
        end else begin
            w_s = {w_tap_a[DataWidth-1], w_tap_a} - {w_tap_b[DataWidth-1], w_tap_b};
        end
        w_coef = {{(AccW - CoeffWidth){r_active[r_pass][CoeffWidth-1]}}, r_active[r_pass]};
        w_term = w_coef << r_bit;
        if (!w_s[r_bit]) begin
            w_acc_next = r_acc;
        end else if (r_bit == BitW'(DataWidth)) begin
            w_acc_next = r_acc - w_term;
        end else begin
            w_acc_next = r_acc + w_term;
        end
    end

    // Round half-up to the sample grid, then clip to the output range.
    always_comb begin
        w_q = (r_acc + RndBias) >>> (CoeffWidth - 1);
        if (w_q > YMax) begin
            w_y   = YMax[DataWidth-1:0];
            w_sat = 1'b1;
        end else if (w_q < YMin) begin
            w_y   = YMin[DataWidth-1:0];
            w_sat = 1'b1;
        end else begin
            w_y   = w_q[DataWidth-1:0];
            w_sat = 1'b0;
        end
    end

    // Per-channel delay lines; tap 0 holds the newest sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int c = 0; c < NChannels; c++) begin
                for (int t = 0; t < NTaps; t++) begin
                    r_line[c][t] <= '0;
                end
            end
        end else if (w_go) begin
            for (int t = NTaps - 1; t > 0; t--) begin
                r_line[i_in_ch][t] <= r_line[i_in_ch][t-1];
            end
            r_line[i_in_ch][0] <= i_x;
        end
    end

    // Coefficient banks: the active copy only changes while the datapath is idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int k = 0; k < NCoeffs; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
            r_commit_pend <= 1'b0;
        end else begin
            if (i_coeff_we) begin
                r_shadow[i_coeff_addr] <= i_coeff_wdata;
            end
            if (((r_state == S_IDLE) && !w_go && (i_coeff_commit || r_commit_pend)) ||
                (w_to_idle && (i_coeff_commit || r_commit_pend))) begin
                r_active      <= r_shadow;
                r_commit_pend <= 1'b0;
            end else if (i_coeff_commit) begin
                r_commit_pend <= 1'b1;
            end
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_pass      <= '0;
            r_bit       <= '0;
            r_ch        <= '0;
            r_sym       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_y         <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state    <= S_MAC;
                        r_in_ready <= 1'b0;
                        r_ch       <= i_in_ch;
                        r_sym      <= i_sym_coeffs;
                        r_acc      <= '0;
                        r_pass     <= '0;
                        r_bit      <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    if (r_bit == BitW'(DataWidth)) begin
                        r_bit <= '0;
                        if (w_last_pass) begin
                            r_state <= S_OUT;
                        end else begin
                            r_pass <= r_pass + 1'b1;
                        end
                    end else begin
                        r_bit <= r_bit + 1'b1;
                    end
                end
                S_OUT: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_y         <= w_y;
                        r_out_sat   <= w_sat;
                        r_out_ch    <= r_ch;
                    end else if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_commit_pend = r_commit_pend;
    assign o_in_ready    = r_in_ready;
    assign o_out_valid   = r_out_valid;
    assign o_out_ch      = r_out_ch;
    assign o_y           = r_y;
    assign o_out_sat     = r_out_sat;
endmodule

// File: tb/tb_fir_multichannel.sv
// Randomised and directed bench for fir_multichannel against a direct-form
// arithmetic reference model of the filter and its coefficient banks.
module tb_fir_multichannel;
    localparam int DW  = 12;
    localparam int CW  = 12;
    localparam int NT  = 9;
    localparam int NCH = 2;
    localparam int NC  = (NT + 1) / 2;
    localparam int CHW = 1;
    localparam int CAW = 3;
    localparam int LAT = NC * (DW + 1) + 1;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic           i_sym_coeffs;
    logic           i_coeff_we;
    logic [CAW-1:0] i_coeff_addr;
    logic [CW-1:0]  i_coeff_wdata;
    logic           i_coeff_commit;
    logic           o_commit_pend;
    logic           i_in_valid;
    logic           o_in_ready;
    logic [CHW-1:0] i_in_ch;
    logic [DW-1:0]  i_x;
    logic           o_out_valid;
    logic           i_out_ready;
    logic [CHW-1:0] o_out_ch;
    logic [DW-1:0]  o_y;
    logic           o_out_sat;

    always #5 i_clk = ~i_clk;

    fir_multichannel #(.DataWidth(DW), .CoeffWidth(CW), .NTaps(NT), .NChannels(NCH)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sym_coeffs(i_sym_coeffs),
        .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_wdata(i_coeff_wdata),
        .i_coeff_commit(i_coeff_commit), .o_commit_pend(o_commit_pend),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_ch(i_in_ch), .i_x(i_x),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_ch(o_out_ch),
        .o_y(o_y), .o_out_sat(o_out_sat)
    );

    int  n_checks = 0;
    int  n_fail   = 0;
    int  hist   [NCH][NT];
    int  shadow [NC];
    int  active [NC];
    bit  pend_m;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sx(input int v, input int w);
        int m;
        m = v & ((1 << w) - 1);
        if (m >= (1 << (w - 1))) m = m - (1 << w);
        return m;
    endfunction

    // Direct-form reference: sum of coefficient * (tap pair) with round and clip.
    function automatic longint model_y(input int ch, input bit sym, output bit sat);
        longint acc;
        longint q;
        longint ymax;
        acc = 0;
        ymax = (longint'(1) << (DW - 1)) - 1;
        for (int k = 0; k < NC - 1; k++) begin
            if (sym) acc += longint'(active[k]) * longint'(hist[ch][k] + hist[ch][NT-1-k]);
            else     acc += longint'(active[k]) * longint'(hist[ch][k] - hist[ch][NT-1-k]);
        end
        acc += longint'(active[NC-1]) * longint'(hist[ch][NT/2]);
        q = (acc + (longint'(1) << (CW - 2))) >>> (CW - 1);
        sat = 1'b0;
        if (q > ymax) begin
            q = ymax;
            sat = 1'b1;
        end else if (q < -ymax - 1) begin
            q = -ymax - 1;
            sat = 1'b1;
        end
        return q;
    endfunction

    task automatic clear_model();
        for (int c = 0; c < NCH; c++)
            for (int t = 0; t < NT; t++) hist[c][t] = 0;
        for (int k = 0; k < NC; k++) begin
            shadow[k] = 0;
            active[k] = 0;
        end
        pend_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_model();
    endtask

    task automatic write_coef(input int a, input int v);
        @(negedge i_clk);
        i_coeff_we    = 1'b1;
        i_coeff_addr  = a[CAW-1:0];
        i_coeff_wdata = v[CW-1:0];
        @(negedge i_clk);
        i_coeff_we = 1'b0;
        shadow[a] = sx(v, CW);
    endtask

    task automatic commit_idle();
        @(negedge i_clk);
        i_coeff_commit = 1'b1;
        @(negedge i_clk);
        i_coeff_commit = 1'b0;
        for (int k = 0; k < NC; k++) active[k] = shadow[k];
        check_val("pend_idle", longint'(o_commit_pend), 0);
    endtask

    task automatic run_sample(input int ch, input int xv, input bit sym, input int hold,
                              input bit mid_commit, output longint y_got, output bit sat_got);
        int     k;
        longint y_e;
        bit     sat_e;
        @(negedge i_clk);
        i_in_valid   = 1'b1;
        i_in_ch      = ch[CHW-1:0];
        i_x          = xv[DW-1:0];
        i_sym_coeffs = sym;
        i_out_ready  = (hold == 0);
        k = 0;
        while (!o_in_ready && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check_val("in_ready_wait", longint'(k < 200), 1);
        @(posedge i_clk);
        for (int t = NT - 1; t > 0; t--) hist[ch][t] = hist[ch][t-1];
        hist[ch][0] = sx(xv, DW);
        y_e = model_y(ch, sym, sat_e);
        @(negedge i_clk);
        i_in_valid   = 1'b0;
        i_sym_coeffs = ~sym;
        i_x          = DW'($urandom_range(0, 4095));
        check_val("in_ready_busy", longint'(o_in_ready), 0);
        k = 0;
        while (!o_out_valid && k < 300) begin
            if (mid_commit && k == 10) i_coeff_commit = 1'b1;
            if (mid_commit && k == 11) begin
                i_coeff_commit = 1'b0;
                pend_m = 1'b1;
                check_val("pend_mid", longint'(o_commit_pend), 1);
            end
            @(negedge i_clk);
            k++;
        end
        check_val("latency", k, LAT);
        y_got   = longint'($signed(o_y));
        sat_got = o_out_sat;
        check_val("y", y_got, y_e);
        check_val("sat", longint'(o_out_sat), longint'(sat_e));
        check_val("out_ch", longint'(o_out_ch), ch);
        for (int j = 0; j < hold; j++) begin
            @(negedge i_clk);
            check_val("hold_valid", longint'(o_out_valid), 1);
            check_val("hold_y", longint'($signed(o_y)), y_e);
            check_val("hold_ch", longint'(o_out_ch), ch);
            check_val("hold_in_ready", longint'(o_in_ready), 0);
        end
        i_out_ready = 1'b1;
        @(negedge i_clk);
        check_val("valid_drop", longint'(o_out_valid), 0);
        check_val("in_ready_back", longint'(o_in_ready), 1);
        if (pend_m) begin
            for (int q = 0; q < NC; q++) active[q] = shadow[q];
            pend_m = 1'b0;
            check_val("pend_clr", longint'(o_commit_pend), 0);
        end
    endtask

    initial begin : main
        longint yg;
        bit     sg;
        int     seen;
        int     seq1 [6] = '{1000, 0, 0, 0, 0, 0};
        i_rst = 1'b1;
        i_sym_coeffs = 1'b1;
        i_coeff_we = 1'b0;
        i_coeff_addr = '0;
        i_coeff_wdata = '0;
        i_coeff_commit = 1'b0;
        i_in_valid = 1'b0;
        i_in_ch = '0;
        i_x = '0;
        i_out_ready = 1'b1;
        clear_model();
        repeat (3) @(negedge i_clk);
        check_val("rst_in_ready", longint'(o_in_ready), 1);
        check_val("rst_out_valid", longint'(o_out_valid), 0);
        check_val("rst_y", longint'(o_y), 0);
        check_val("rst_out_ch", longint'(o_out_ch), 0);
        check_val("rst_sat", longint'(o_out_sat), 0);
        check_val("rst_pend", longint'(o_commit_pend), 0);
        i_rst = 1'b0;

        // Impulse through the centre tap.
        write_coef(4, 12'h400);
        commit_idle();
        for (int i = 0; i < 6; i++) begin
            run_sample(0, seq1[i], 1'b1, 0, 1'b0, yg, sg);
            check_val("t1_y", yg, (i == 4) ? 500 : 0);
        end

        do_reset();
        for (int k = 0; k < NC; k++) write_coef(k, 12'h100);
        commit_idle();
        for (int i = 0; i < 9; i++) run_sample(0, 1000, 1'b1, 0, 1'b0, yg, sg);
        check_val("t2_y9", yg, 1125);
        check_val("t2_sat", longint'(sg), 0);

        do_reset();
        for (int k = 0; k < NC; k++) write_coef(k, 12'h7FF);
        commit_idle();
        for (int i = 0; i < 9; i++) run_sample(0, 2047, 1'b1, 0, 1'b0, yg, sg);
        check_val("t3_pos_y", yg, 2047);
        check_val("t3_pos_sat", longint'(sg), 1);
        for (int i = 0; i < 9; i++) run_sample(0, -2048, 1'b1, 0, 1'b0, yg, sg);
        check_val("t3_neg_y", yg, -2048);
        check_val("t3_neg_sat", longint'(sg), 1);

        // Antisymmetric pre-add on channel 1.
        do_reset();
        write_coef(0, 12'h400);
        commit_idle();
        run_sample(1, 800, 1'b0, 0, 1'b0, yg, sg);
        check_val("t4_first", yg, 400);
        for (int i = 0; i < 8; i++) run_sample(1, 0, 1'b0, 0, 1'b0, yg, sg);
        check_val("t4_ninth", yg, -400);

        do_reset();
        write_coef(4, 12'h400);
        commit_idle();
        for (int i = 0; i < 6; i++) begin
            run_sample(0, 100, 1'b1, (i == 3) ? 20 : 0, 1'b0, yg, sg);
            run_sample(1, -100, 1'b1, 0, 1'b0, yg, sg);
        end
        check_val("t5_ch1", yg, -50);

        // Commit while busy, then write-with-commit in the same cycle.
        do_reset();
        write_coef(0, 12'h400);
        commit_idle();
        write_coef(0, 12'h200);
        run_sample(0, 800, 1'b1, 0, 1'b1, yg, sg);
        check_val("t6_old_bank", yg, 400);
        run_sample(0, 0, 1'b1, 0, 1'b0, yg, sg);
        run_sample(0, 800, 1'b1, 0, 1'b0, yg, sg);
        check_val("t6_new_bank", yg, 200);
        write_coef(0, 12'h600);
        @(negedge i_clk);
        i_coeff_we = 1'b1;
        i_coeff_addr = 3'd0;
        i_coeff_wdata = 12'h100;
        i_coeff_commit = 1'b1;
        @(negedge i_clk);
        i_coeff_we = 1'b0;
        i_coeff_commit = 1'b0;
        for (int k = 0; k < NC; k++) active[k] = shadow[k];
        shadow[0] = 12'h100;
        run_sample(0, 800, 1'b1, 0, 1'b0, yg, sg);
        check_val("t6_prewrite", yg, 600);

        // Reset in the middle of a MAC.
        @(negedge i_clk);
        i_in_valid = 1'b1;
        i_in_ch = 1'b0;
        i_x = 12'd500;
        @(posedge i_clk);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        repeat (20) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_model();
        seen = 0;
        repeat (80) begin
            @(negedge i_clk);
            if (o_out_valid) seen++;
        end
        check_val("t7_no_out", seen, 0);
        check_val("t7_in_ready", longint'(o_in_ready), 1);
        write_coef(1, 12'h400);
        commit_idle();
        run_sample(0, 200, 1'b1, 0, 1'b0, yg, sg);
        check_val("t7_zero_hist", yg, 0);

        // Randomised traffic with occasional coefficient updates.
        do_reset();
        for (int k = 0; k < NC; k++) write_coef(k, int'($urandom_range(0, 4095)));
        commit_idle();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                write_coef(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 4095)));
                commit_idle();
            end
            run_sample(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 4095)),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                       (i % 13) == 5, yg, sg);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
